aclk_key_entry: RTL

//  Keypad entry sequencer: producer side of the alarm/time register load interface.

---
 rtl/aclk_key_entry.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/aclk_key_entry.sv
// Keypad entry sequencer: collects up to four BCD digits, validates them as HH:MM and
// issues a one-cycle load pulse to either the alarm register or the clock counter.
module aclk_key_entry #(
    parameter int         TIMEOUT_SEC = 10,
    parameter logic [3:0] KEY_ALARM   = 4'hA,
    parameter logic [3:0] KEY_TIME    = 4'hB,
    parameter logic [3:0] KEY_CLEAR   = 4'hC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       one_second,
    output logic [3:0] new_alarm_ms_hr,
    output logic [3:0] new_alarm_ls_hr,
    output logic [3:0] new_alarm_ms_min,
    output logic [3:0] new_alarm_ls_min,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       entry_active,
    output logic [2:0] digit_count,
    output logic       entry_error,
    output logic [1:0] fsm_state
);

    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTRY  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t        state, next_state;
    logic [15:0]   digits, digits_d;
    logic [2:0]    count_d;
    logic [TW-1:0] tick_cnt, tick_d;
    logic          load_a_d, load_c_d, error_d, active_d;

    logic is_digit, is_alarm, is_time, is_clear, is_commit, timeout, time_ok;

    assign is_digit  = key_valid && (key <= 4'd9);
    assign is_alarm  = key_valid && (key == KEY_ALARM);
    assign is_time   = key_valid && (key == KEY_TIME);
    assign is_clear  = key_valid && (key == KEY_CLEAR);
    assign is_commit = is_alarm || is_time;

    // A tick coinciding with any key strobe is discarded.
    assign timeout = one_second && !key_valid && (tick_cnt == TW'(TIMEOUT_SEC - 1));

    assign time_ok = (digit_count == 3'd4)
                  && (digits[15:12] <= 4'd2)
                  && ((digits[15:12] != 4'd2) || (digits[11:8] <= 4'd3))
                  && (digits[11:8] <= 4'd9)
                  && (digits[7:4] <= 4'd5)
                  && (digits[3:0] <= 4'd9);

    assign new_alarm_ms_hr  = digits[15:12];
    assign new_alarm_ls_hr  = digits[11:8];
    assign new_alarm_ms_min = digits[7:4];
    assign new_alarm_ls_min = digits[3:0];
    assign fsm_state        = state;

    always_ff @(posedge clk) begin : state_register
        if (reset) begin
            state        <= S_IDLE;
            digits       <= '0;
            digit_count  <= '0;
            tick_cnt     <= '0;
            load_new_a   <= 1'b0;
            load_new_c   <= 1'b0;
            entry_error  <= 1'b0;
            entry_active <= 1'b0;
        end else begin
            state        <= next_state;
            digits       <= digits_d;
            digit_count  <= count_d;
            tick_cnt     <= tick_d;
            load_new_a   <= load_a_d;
            load_new_c   <= load_c_d;
            entry_error  <= error_d;
            entry_active <= active_d;
        end
    end

    always_comb begin : next_state_logic
        next_state = state;
        case (state)
            S_IDLE:   if (is_digit) next_state = S_ENTRY;
            S_ENTRY: begin
                if (is_digit)       next_state = S_ENTRY;
                else if (is_clear)  next_state = S_IDLE;
                else if (is_commit) next_state = time_ok ? S_COMMIT : S_IDLE;
                else if (timeout)   next_state = S_IDLE;
            end
            S_COMMIT: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Computes the next value of every registered output.
    always_comb begin : output_logic
        digits_d = digits;
        count_d  = digit_count;
        tick_d   = tick_cnt;
        load_a_d = 1'b0;
        load_c_d = 1'b0;
        error_d  = 1'b0;
        active_d = (next_state == S_ENTRY);
        case (state)
            S_IDLE: begin
                if (is_digit) begin
                    digits_d = {12'h000, key};
                    count_d  = 3'd1;
                    tick_d   = '0;
                end
            end
            S_ENTRY: begin
                if (is_digit) begin
                    digits_d = {digits[11:0], key};
                    count_d  = (digit_count == 3'd4) ? 3'd4 : digit_count + 3'd1;
                    tick_d   = '0;
                end else if (is_clear) begin
                    digits_d = '0;
                    count_d  = '0;
                    tick_d   = '0;
                end else if (is_commit) begin
                    tick_d = '0;
                    if (time_ok) begin
                        load_a_d = is_alarm;
                        load_c_d = is_time;
                    end else begin
                        error_d  = 1'b1;
                        digits_d = '0;
                        count_d  = '0;
                    end
                end else if (one_second && !key_valid) begin
                    if (timeout) begin
                        error_d  = 1'b1;
                        digits_d = '0;
                        count_d  = '0;
                        tick_d   = '0;
                    end else begin
                        tick_d = tick_cnt + 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                // Digits stay on the bus as the last committed value.
                count_d = '0;
                tick_d  = '0;
            end
            default: begin
                digits_d = '0;
                count_d  = '0;
                tick_d   = '0;
            end
        endcase
    end

endmodule
